// File: rtl/aes_pkg.sv
// Shared AES decryption constants, FSM encoding and the InvSbox table.
// Used by the iterative InvSubBytes stage and the future inverse key expansion.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int BYTE_W      = 8;
  localparam int COL_W       = 32;
  localparam int NUM_COLS    = AES_STATE_W / COL_W;
  localparam int COL_BYTES   = COL_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sub_bytes_iter_sbox.sv
// Single-byte inverse S-box: combinational lookup into the shared table.
// Instantiated once per byte of the column being substituted.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = INV_SBOX[x];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: one 32-bit column per cycle through four shared
// inverse S-boxes, valid/ready on both sides, registered handshake outputs.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] state_out,
  output logic         out_valid,
  input  logic         out_ready
);

  if (COLS_PER_CYCLE != 1) begin : g_bad_cfg
    $error("inv_sub_bytes_iter: only COLS_PER_CYCLE = 1 is supported");
  end

  fsm_e                   st;
  logic [1:0]             col;
  logic [AES_STATE_W-1:0] work;
  logic [COL_W-1:0]       col_in;
  logic [COL_W-1:0]       col_out;

  assign col_in = work[{col, 5'd0} +: COL_W];

  for (genvar b = 0; b < COL_BYTES; b++) begin : g_sbox
    inv_sbox u_sbox (
      .x (col_in[b*BYTE_W +: BYTE_W]),
      .y (col_out[b*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      col       <= 2'd0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            work     <= state_in;
            col      <= 2'd0;
            st       <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          work[{col, 5'd0} +: COL_W] <= col_out;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Data is consumed on this edge; next acceptance happens from IDLE
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st        <= IDLE;
          col       <= 2'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = work;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed and randomized checks for the iterative InvSubBytes stage.
// Reference InvSbox is derived from GF(2^8) inversion and the inverse affine map.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_out;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]   ref_tab [256];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.COLS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_out (state_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] inv_sb(input logic [7:0] t);
    logic [7:0] x;
    x = {t[6:0], t[7]} ^ {t[4:0], t[7:5]} ^ {t[1:0], t[7:2]} ^ 8'h05;
    return ginv(x);
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[s[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    int n;
    state_in = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_data"}, state_out, exp);
  endtask

  initial begin
    logic [127:0] all01, all09, allff, all7d, all63;
    int sent, got, cyc, seen;
    bit fire_in, fire_out;

    for (int i = 0; i < 256; i++) ref_tab[i] = inv_sb(i[7:0]);
    all01 = {16{8'h01}};
    all09 = {16{8'h09}};
    allff = {16{8'hff}};
    all7d = {16{8'h7d}};
    all63 = {16{8'h63}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    #1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_state_out", state_out, 128'h0);

    out_ready = 1'b1;
    send(128'h0);
    wait_out("zero", {16{8'h52}});
    step();
    chk("zero_in_ready", in_ready, 1'b1);
    chk("zero_out_valid", out_valid, 1'b0);

    send({{10{8'h7c}}, 48'hffff_ff63_0001});
    wait_out("mixed", {{10{8'h01}}, 48'h7d7d_7d00_5209});
    step();

    out_ready = 1'b0;
    send(all01);
    wait_out("bp", all09);
    state_in = allff;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", state_out, all09);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ir", in_ready, 1'b1);
    chk("bp_release_ov", out_valid, 1'b0);
    step();
    chk("bp_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out("bp_next", all7d);
    step();

    send(128'h0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ir", in_ready, 1'b1);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_data", state_out, 128'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mid_rst_no_out", seen, 0);
    send(all63);
    wait_out("after_rst", 128'h0);
    step();

    sent = 0; got = 0; cyc = 0;
    in_valid = 1'b0;
    while (got < 1000 && cyc < 40000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_in) begin
        exp_q.push_back(ref_state(state_in));
        sent++;
      end
      if (fire_out) begin
        if (exp_q.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd_data", state_out, exp_q.pop_front());
        got++;
      end
      step();
      cyc++;
      if (fire_in) in_valid = 1'b0;
    end
    chk("rnd_count", got, 1000);
    chk("rnd_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
